branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Fetch-side direction predictor feeding the EX-stage branch resolver.
//  - Table of 2-bit saturating counters indexed by the IF-stage PC; drives the taken-prediction used by IF.
//  - Carries each prediction through IF/ID and ID/EX registers so EX sees it on bp_ex.
//  - Trains on the resolver's bp_update/bp_taken outcome for the PC in EX.
// PARAMETERS
//  ENTRIES  64  number of counters; power of two, >= 2
//  IDX_W    6   log2(ENTRIES); index = pc[IDX_W-1:0] (PC is word-addressed, +1 per instr)
//  INIT_CTR 2'b01  counter value after reset (weakly not-taken)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  pc_if       in   32  PC of instruction in IF
//  pred_if     out  1   prediction for pc_if (combinational from table)
//  stall       in   1   pipeline hold: freezes IF/ID and ID/EX prediction regs, blocks training
//  flush       in   1   mispredict/jump flush from EX resolver (its 'taken')
//  bp_ex       out  1   prediction belonging to the instruction now in EX
//  pc_ex       in   32  PC of instruction in EX
//  bp_update   in   1   EX holds a conditional branch: train this cycle
//  bp_taken    in   1   actual outcome of that branch
//  branch_cnt  out  32  (BP_STATS_EN only) resolved conditional branches
//  miss_cnt    out  32  (BP_STATS_EN only) resolved branches whose bp_ex != bp_taken
// BEHAVIOUR
//  Reset (async, rst=1): all counters <= INIT_CTR; pred_id, bp_ex <= 0; stats <= 0.
//  Read: pred_if = ctr[pc_if[IDX_W-1:0]][1]; zero-cycle, no bypass.
//  Write: on posedge when bp_update && !stall, ctr[pc_ex[IDX_W-1:0]]:
//   - bp_taken=1: +1, saturate at 2'b11; bp_taken=0: -1, saturate at 2'b00.
//   - Same-index read/write in one cycle: pred_if reflects the pre-update value.
//   - Write ignores flush (the resolving branch is valid even while flushing younger ops).
//  Pipeline (per posedge, priority flush > stall > advance):
//   - flush: pred_id <= 0, bp_ex <= 0 (bubbles carry no prediction).
//   - stall && !flush: pred_id, bp_ex hold.
//   - else: pred_id <= pred_if; bp_ex <= pred_id.
//  Latency: prediction made in IF at cycle t appears on bp_ex at t+2 (no stall/flush).
//  Aliasing: PCs equal in pc[IDX_W-1:0] share a counter; no tags, intended.
//  bp_update with bp_ex/pc_ex from a flushed bubble: not produced by resolver; no check.
//  Reset mid-operation: table and pipeline return to reset values immediately; no partial training.
// CONFIGURATION
//  BP_STATS_EN defined:
//   - branch_cnt += 1 on each training cycle (bp_update && !stall).
//   - miss_cnt += 1 when additionally bp_ex != bp_taken.
//   - Both wrap modulo 2^32.
//  BP_STATS_EN undefined: branch_cnt/miss_cnt ports and counters absent; zero added logic.
// TESTING
//  1 Reset: rst=1 async mid-cycle -> pred_if=0 for any pc_if, bp_ex=0, all ctr=01, stats=0.
//  2 Training saturation: bp_update=1, bp_taken=1, pc_ex=0x05 for 3 cycles ->
//    ctr[5] 01->10->11->11; pc_if=0x05 gives pred_if=1 after 1st update;
//    then 4x bp_taken=0 -> 11->10->01->00->00, pred_if=0 after 2nd.
//  3 Pipeline/latency: ctr[3]=11, pc_if=0x03 at cycle t, no stall/flush ->
//    bp_ex=1 at t+2 only; pc_if=0x04 (ctr=01) at t+1 -> bp_ex=0 at t+3.
//  4 Stall/flush priority: pred_id=1 with stall=1 and flush=1 -> pred_id=0, bp_ex=0 next cycle;
//    stall=1 alone for 3 cycles -> bp_ex unchanged, bp_update=1 causes no ctr change.
//  5 Aliasing/same-cycle: pc_if=0x45, pc_ex=0x05 (ENTRIES=64), ctr=01, bp_update=1, bp_taken=1 ->
//    pred_if=0 that cycle, pred_if=1 next cycle.
//  6 BP_STATS_EN: 10 trained branches, 3 with bp_ex!=bp_taken, 2 during stall ->
//    branch_cnt=8, miss_cnt=3 (only if none of the 3 stalled); preload 0xFFFFFFFF + 1 -> 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side 2-bit counter direction predictor with IF/ID/EX prediction carry.
// Optional hit/miss statistics are built when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] INIT_CTR = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_if,
    output logic        pred_if,
    input  logic        stall,
    input  logic        flush,
    output logic        bp_ex,
    input  logic [31:0] pc_ex,
    input  logic        bp_update,
`ifdef BP_STATS_EN
    input  logic        bp_taken,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
`else
    input  logic        bp_taken
`endif
);

    logic [1:0]       ctr [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       cur;
    logic [1:0]       nxt;
    logic             train;
    logic             pred_id;
    logic             unused_pc;

    assign rd_idx    = pc_if[IDX_W-1:0];
    assign wr_idx    = pc_ex[IDX_W-1:0];
    assign unused_pc = ^{pc_if[31:IDX_W], pc_ex[31:IDX_W]};
    assign train     = bp_update && !stall;
    assign pred_if   = ctr[rd_idx][1];
    assign cur       = ctr[wr_idx];

    // Saturating step of the counter owned by the branch in EX.
    always_comb begin
        nxt = cur;
        if (bp_taken) begin
            if (cur != 2'b11) nxt = cur + 2'd1;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'd1;
        end
    end

    // Counter table; training is not gated by flush, only by stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_CTR;
        end else if (train) begin
            ctr[wr_idx] <= nxt;
        end
    end

    // Prediction carry: flush inserts empty bubbles, stall holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_id <= 1'b0;
            bp_ex   <= 1'b0;
        end else if (flush) begin
            pred_id <= 1'b0;
            bp_ex   <= 1'b0;
        end else if (!stall) begin
            pred_id <= pred_if;
            bp_ex   <= pred_id;
        end
    end

`ifdef BP_STATS_EN
    // Resolved-branch and misprediction counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (train) begin
            branch_cnt <= branch_cnt + 32'd1;
            if (bp_ex != bp_taken) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with an abstract reference model
// and per-cycle comparison; stats checks built when BP_STATS_EN is defined.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_if = '0;
    logic        pred_if;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        bp_ex;
    logic [31:0] pc_ex = '0;
    logic        bp_update = 1'b0;
    logic        bp_taken = 1'b0;
`ifdef BP_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference: integer counters, a two-slot shift of predictions.
    int          m_ctr [64];
    bit          m_pipe [2];
    int unsigned m_br = 0;
    int unsigned m_miss = 0;

    branch_predictor dut (
        .clk       (clk),
        .rst       (rst),
        .pc_if     (pc_if),
        .pred_if   (pred_if),
        .stall     (stall),
        .flush     (flush),
        .bp_ex     (bp_ex),
        .pc_ex     (pc_ex),
        .bp_update (bp_update),
`ifdef BP_STATS_EN
        .bp_taken  (bp_taken),
        .branch_cnt(branch_cnt),
        .miss_cnt  (miss_cnt)
`else
        .bp_taken  (bp_taken)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_pred(input logic [31:0] pc);
        return m_ctr[pc % 64] >= 2;
    endfunction

    // Model state update from the rules, using pre-edge inputs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_ctr[i]) m_ctr[i] = 1;
            m_pipe[0] = 0;
            m_pipe[1] = 0;
            m_br = 0;
            m_miss = 0;
        end else begin
            bit p;
            bit old_ex;
            p = m_pred(pc_if);
            old_ex = m_pipe[1];
            if (flush) begin
                m_pipe[0] = 0;
                m_pipe[1] = 0;
            end else if (!stall) begin
                m_pipe[1] = m_pipe[0];
                m_pipe[0] = p;
            end
            if (bp_update && !stall) begin
                int k;
                k = pc_ex % 64;
                if (bp_taken) m_ctr[k] = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
                else          m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
                m_br = m_br + 1;
                if (old_ex != bp_taken) m_miss = m_miss + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_pred_if", {31'd0, pred_if}, {31'd0, m_pred(pc_if)});
            check("model_bp_ex", {31'd0, bp_ex}, {31'd0, m_pipe[1]});
`ifdef BP_STATS_EN
            check("model_branch_cnt", branch_cnt, m_br);
            check("model_miss_cnt", miss_cnt, m_miss);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train_on(input logic [31:0] pc, input logic t);
        bp_update = 1'b1;
        pc_ex = pc;
        bp_taken = t;
        tick();
        bp_update = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #12 rst = 1'b0;
        #1;
        cmp_en = 1'b1;
        check("reset_pred_if", {31'd0, pred_if}, 32'd0);
        check("reset_bp_ex", {31'd0, bp_ex}, 32'd0);

        // Saturation up then down on index 5.
        pc_if = 32'h05;
        bp_update = 1'b1;
        pc_ex = 32'h05;
        bp_taken = 1'b1;
        tick(); check("sat_up1", {31'd0, pred_if}, 32'd1);
        tick(); check("sat_up2", {31'd0, pred_if}, 32'd1);
        tick(); check("sat_up3", {31'd0, pred_if}, 32'd1);
        bp_taken = 1'b0;
        tick(); check("sat_dn1", {31'd0, pred_if}, 32'd1);
        tick(); check("sat_dn2", {31'd0, pred_if}, 32'd0);
        tick(); check("sat_dn3", {31'd0, pred_if}, 32'd0);
        tick(); check("sat_dn4", {31'd0, pred_if}, 32'd0);
        bp_update = 1'b0;

        // Latency: counter 3 strong taken, counter 4 weak not-taken.
        pc_if = 32'h04;
        train_on(32'h03, 1'b1);
        train_on(32'h03, 1'b1);
        tick();
        pc_if = 32'h03;
        tick(); check("lat_t1", {31'd0, bp_ex}, 32'd0);
        pc_if = 32'h04;
        tick(); check("lat_t2", {31'd0, bp_ex}, 32'd1);
        tick(); check("lat_t3", {31'd0, bp_ex}, 32'd0);

        // Flush wins over stall and clears the carried prediction.
        pc_if = 32'h03;
        tick();
        stall = 1'b1;
        flush = 1'b1;
        tick(); check("flush_bp_ex", {31'd0, bp_ex}, 32'd0);
        stall = 1'b0;
        flush = 1'b0;
        pc_if = 32'h04;
        tick(); check("flush_pred_id", {31'd0, bp_ex}, 32'd0);

        // Stall holds bp_ex and blocks training.
        pc_if = 32'h03;
        tick();
        tick(); check("pre_stall", {31'd0, bp_ex}, 32'd1);
        stall = 1'b1;
        pc_if = 32'h04;
        bp_update = 1'b1;
        pc_ex = 32'h04;
        bp_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", {31'd0, bp_ex}, 32'd1);
            check("stall_notrain", {31'd0, pred_if}, 32'd0);
        end
        stall = 1'b0;
        bp_update = 1'b0;
        tick(); check("stall_release", {31'd0, bp_ex}, 32'd1);

        // Aliasing with same-cycle update: pre-update value visible.
        train_on(32'h05, 1'b1);
        pc_if = 32'h45;
        pc_ex = 32'h05;
        bp_update = 1'b1;
        bp_taken = 1'b1;
        #1 check("alias_same", {31'd0, pred_if}, 32'd0);
        tick();
        bp_update = 1'b0;
        check("alias_next", {31'd0, pred_if}, 32'd1);

        // Asynchronous reset in the middle of a cycle.
        pc_if = 32'h03;
        #1 check("pre_rst", {31'd0, pred_if}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_pred_if", {31'd0, pred_if}, 32'd0);
        check("async_bp_ex", {31'd0, bp_ex}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

`ifdef BP_STATS_EN
        // 10 trainings: 2 stalled, 3 of the remaining mispredicted.
        check("stats_reset_br", branch_cnt, 32'd0);
        check("stats_reset_miss", miss_cnt, 32'd0);
        pc_if = 32'h10;
        for (int i = 0; i < 10; i++) begin
            stall = (i == 4 || i == 7);
            bp_update = 1'b1;
            pc_ex = 32'h20;
            bp_taken = (i < 3 || i == 4 || i == 7);
            tick();
        end
        stall = 1'b0;
        bp_update = 1'b0;
        check("stats_branch", branch_cnt, 32'd8);
        check("stats_miss", miss_cnt, 32'd3);
`endif

        tick();
        tick();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
